pet2001_vram_arbiter: RTL and testbench
=======================================

Name: pet2001_vram_arbiter

Overview:
Shares the single-port 2 KB PET video RAM between the 6502 bus and the character-fetch path of the video generator. Time is divided into character-cell slots of 8 ce_7mp ticks. One slot per cell is reserved for the video fetch while the raster is active; every other slot is available to the CPU through a req/ack handshake. Sits between the CPU bus decoder, the video timing block and the video RAM macro.

Parameters:
ADDR_W, 11, video RAM address width
DATA_W, 8, video RAM data width
VID_SLOT, 7, char_phase value whose slot is reserved for the video fetch
WAIT_W, 16, width of the CPU wait-slot counter

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
ce_7mp  in  1  pixel-rate clock enable; each asserted cycle starts one slot
char_phase  in  3  hc[2:0] from video timing, sampled on ce_7mp
vid_fetch_en  in  1  raster active (hc<320 && vc<200), sampled on ce_7mp
vid_addr  in  ADDR_W  address of the next character cell to fetch
vid_data  out  DATA_W  last fetched character code, held until the next fetch
vid_valid  out  1  one-clk pulse when vid_data updates
cpu_req  in  1  CPU access request; level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
cpu_rdata  out  DATA_W  read data, valid in the cpu_ack cycle
cpu_ack  out  1  one-clk completion pulse
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data; synchronous, 1-clk latency after ram_en
cpu_wait_cnt  out  WAIT_W  saturating count of slots in which the CPU was deferred

Behaviour:
- Reset (reset_n=0 at a clk edge): every output is 0 and the FSM returns to IDLE. An in-flight op is discarded with no ack and no vid_valid. A RAM write that was already strobed is not undone.
- Clocking: ce_7mp pulses are at least 4 clks apart. This is guaranteed at the integration level and is not checked by the block.
- Slot decision, made only on a clk where ce_7mp=1 and the FSM is in IDLE:
  - Video: char_phase==VID_SLOT and vid_fetch_en=1. Video always has priority.
  - CPU: otherwise, if cpu_req=1.
  - None: otherwise the slot is idle.
- Deferral: if char_phase==VID_SLOT, vid_fetch_en=1 and cpu_req=1, cpu_wait_cnt increments by 1 and saturates at all-ones. No other event changes the counter.
- Blanking: while vid_fetch_en=0, every slot is available to the CPU.
- FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE.
  - Decision edge t: the chosen op is registered, including a snapshot of the address, we and wdata. The FSM goes to ISSUE.
  - Cycle t+1 (ISSUE): ram_en=1 and ram_addr=snapshot. For a CPU write, ram_we=1 and ram_wdata=snapshot; otherwise ram_we=0. ram_en and ram_we are high for exactly this one clk.
  - Cycle t+2 (CAPTURE): ram_rdata is valid. For a video op, vid_data is loaded from ram_rdata. For a CPU op, cpu_rdata is loaded from ram_rdata; on a write, cpu_rdata is loaded with 0 instead.
  - Cycle t+3: vid_valid=1 (video op) or cpu_ack=1 (CPU op), for one clk. The FSM is back in IDLE.
- Latency:
  - CPU completion is 3 clks after the granting ce_7mp.
  - Worst-case wait is one deferred slot plus the granted slot.
- CPU handshake rules:
  - After cpu_ack, a cpu_req still high in the next decision slot is treated as a new request. Masters drop cpu_req in the ack cycle.
  - If cpu_req drops before a grant, the request is silently abandoned.
  - If cpu_req drops after a grant, the op still completes, cpu_ack still pulses, and a write still lands.
- Outputs between ops: vid_data and cpu_rdata hold their last value. ram_addr and ram_wdata are don't-care while ram_en=0.

Decomposition:
- Package pet2001_vram_pkg holds:
  - state enum {IDLE, ISSUE, CAPTURE}
  - owner enum {OWN_NONE, OWN_VID, OWN_CPU}
  - default VID_SLOT and slot-length constant 8
- Optional sub-module pet2001_sat_counter (parameterised width, inc/clear) for cpu_wait_cnt. The rest stays flat.

Test Plan:
- Reset: set all outputs nonzero, drive reset_n=0 for 1 clk -> all outputs 0, FSM in IDLE, cpu_wait_cnt=0.
- Video fetch: vid_fetch_en=1, char_phase=7 on ce_7mp, vid_addr=0x123, RAM[0x123]=0x41 -> ram_en with ram_addr=0x123 at t+1; vid_data=0x41 and vid_valid=1 at t+3.
- CPU write then read while blanked: write 0xA5 to 0x7FF at phase 3, then read 0x7FF -> ram_we=1 for one clk with ram_wdata=0xA5; second ack returns cpu_rdata=0xA5; each ack 3 clks after its grant.
- Collision: cpu_req rises with char_phase=7 and vid_fetch_en=1 -> video served first; CPU granted at phase 0; cpu_wait_cnt 0->1; cpu_ack 3 clks after the phase-0 ce_7mp.
- Saturation with WAIT_W=2: force 5 collisions -> cpu_wait_cnt reads 1,2,3,3,3.
- Reset mid-op: reset_n=0 at cycle t+1 of a CPU read -> no cpu_ack; next grant behaves normally.

Source files
------------

// File: rtl/pet2001_vram_pkg.sv
// Shared types and constants for the PET video RAM arbiter.
// Slot timing is eight ce_7mp ticks per character cell.
package pet2001_vram_pkg;

   localparam int SLOT_LEN     = 8;
   localparam int PHASE_W      = $clog2(SLOT_LEN);
   localparam int DEF_VID_SLOT = 7;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_VID,
      OWN_CPU
   } owner_t;

endpackage

// File: rtl/pet2001_sat_counter.sv
// Up-counter that sticks at all-ones; used to count CPU slot deferrals.
module pet2001_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pet2001_vram_arbiter.sv
// Time-slot arbiter sharing the PET video RAM between the video fetch
// and the CPU; video owns one slot per cell while the raster is active.
module pet2001_vram_arbiter
   import pet2001_vram_pkg::*;
#(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 8,
   parameter int VID_SLOT = DEF_VID_SLOT,
   parameter int WAIT_W   = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               ce_7mp,
   input  logic [PHASE_W-1:0] char_phase,
   input  logic               vid_fetch_en,
   input  logic [ADDR_W-1:0]  vid_addr,
   output logic [DATA_W-1:0]  vid_data,
   output logic               vid_valid,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [DATA_W-1:0]  cpu_wdata,
   output logic [DATA_W-1:0]  cpu_rdata,
   output logic               cpu_ack,
   output logic               ram_en,
   output logic               ram_we,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [DATA_W-1:0]  ram_wdata,
   input  logic [DATA_W-1:0]  ram_rdata,
   output logic [WAIT_W-1:0]  cpu_wait_cnt
);

   state_t state;
   owner_t owner;
   logic   op_we;
   logic   vid_hit;
   logic   defer;

   assign vid_hit = vid_fetch_en && (char_phase == PHASE_W'(VID_SLOT));
   assign defer   = ce_7mp && (state == IDLE) && vid_hit && cpu_req;

   pet2001_sat_counter #(
      .W (WAIT_W)
   ) u_wait_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (defer),
      .clear   (1'b0),
      .count   (cpu_wait_cnt)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         owner     <= OWN_NONE;
         op_we     <= 1'b0;
         vid_data  <= '0;
         vid_valid <= 1'b0;
         cpu_rdata <= '0;
         cpu_ack   <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         // NOTE: completion pulses default low here so each fires for exactly one clk.
         vid_valid <= 1'b0;
         cpu_ack   <= 1'b0;
         case (state)
            IDLE: begin
               if (ce_7mp) begin
                  if (vid_hit) begin
                     owner     <= OWN_VID;
                     op_we     <= 1'b0;
                     ram_en    <= 1'b1;
                     ram_we    <= 1'b0;
                     ram_addr  <= vid_addr;
                     ram_wdata <= '0;
                     state     <= ISSUE;
                  end else if (cpu_req) begin
                     owner     <= OWN_CPU;
                     op_we     <= cpu_we;
                     ram_en    <= 1'b1;
                     ram_we    <= cpu_we;
                     ram_addr  <= cpu_addr;
                     ram_wdata <= cpu_wdata;
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               ram_en <= 1'b0;
               ram_we <= 1'b0;
               state  <= CAPTURE;
            end
            CAPTURE: begin
               // The RAM answers one clk after the strobe, so rdata is valid now.
               if (owner == OWN_VID) begin
                  vid_data  <= ram_rdata;
                  vid_valid <= 1'b1;
               end else begin
                  cpu_rdata <= op_we ? '0 : ram_rdata;
                  cpu_ack   <= 1'b1;
               end
               owner <= OWN_NONE;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pet2001_vram_arbiter.sv
// Scoreboard bench: stimulus queues expected RAM strobes and completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_pet2001_vram_arbiter;
   import pet2001_vram_pkg::*;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               ce_7mp;
   logic [2:0]         char_phase;
   logic               vid_fetch_en;
   logic [10:0]        vid_addr;
   logic [7:0]         vid_data;
   logic               vid_valid;
   logic               cpu_req;
   logic               cpu_we;
   logic [10:0]        cpu_addr;
   logic [7:0]         cpu_wdata;
   logic [7:0]         cpu_rdata;
   logic               cpu_ack;
   logic               ram_en;
   logic               ram_we;
   logic [10:0]        ram_addr;
   logic [7:0]         ram_wdata;
   logic [7:0]         ram_rdata;
   logic [15:0]        cpu_wait_cnt;

   logic [7:0]         s_vid_data, s_cpu_rdata, s_ram_wdata;
   logic               s_vid_valid, s_cpu_ack, s_ram_en, s_ram_we;
   logic [10:0]        s_ram_addr;
   logic [1:0]         s_wait_cnt;

   logic [7:0]         mem [0:2047];

   typedef struct {
      bit         is_vid;
      logic [7:0] data;
      int         cyc;
   } resp_t;

   typedef struct {
      logic        we;
      logic [10:0] addr;
      logic [7:0]  wdata;
      int          cyc;
   } ram_op_t;

   resp_t   resp_q[$];
   ram_op_t ram_q[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [7:0]  exp_vid;
   logic [7:0]  exp_cpu;
   logic [15:0] exp_wait16;
   logic [1:0]  exp_wait2;
   bit          abort_next;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pet2001_vram_arbiter #(.WAIT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .ce_7mp(ce_7mp), .char_phase(char_phase),
      .vid_fetch_en(vid_fetch_en), .vid_addr(vid_addr), .vid_data(vid_data),
      .vid_valid(vid_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .cpu_wait_cnt(cpu_wait_cnt)
   );

   // Narrow-counter copy driven by the same inputs, used for saturation.
   pet2001_vram_arbiter #(.WAIT_W(2)) u_sat (
      .clk(clk), .reset_n(reset_n), .ce_7mp(ce_7mp), .char_phase(char_phase),
      .vid_fetch_en(vid_fetch_en), .vid_addr(vid_addr), .vid_data(s_vid_data),
      .vid_valid(s_vid_valid), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(s_cpu_rdata),
      .cpu_ack(s_cpu_ack), .ram_en(s_ram_en), .ram_we(s_ram_we),
      .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_rdata(ram_rdata),
      .cpu_wait_cnt(s_wait_cnt)
   );

   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         if (ram_we) mem[ram_addr] <= ram_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ram_en) begin
         if (ram_q.size() == 0) begin
            check("unexpected ram_en", 32'd1, 32'd0);
         end else begin
            ram_op_t r;
            r = ram_q.pop_front();
            check("ram_en cycle", cyc, r.cyc);
            check("ram_addr", {21'd0, ram_addr}, {21'd0, r.addr});
            check("ram_we", {31'd0, ram_we}, {31'd0, r.we});
            if (r.we) check("ram_wdata", {24'd0, ram_wdata}, {24'd0, r.wdata});
         end
      end
      if (vid_valid || cpu_ack) begin
         if (resp_q.size() == 0) begin
            check("unexpected completion", {30'd0, vid_valid, cpu_ack}, 32'd0);
         end else begin
            resp_t e;
            e = resp_q.pop_front();
            check("completion kind vid", {31'd0, vid_valid}, {31'd0, e.is_vid});
            check("completion kind cpu", {31'd0, cpu_ack}, {31'd0, !e.is_vid});
            check("completion cycle", cyc, e.cyc);
            if (e.is_vid) check("vid_data", {24'd0, vid_data}, {24'd0, e.data});
            else          check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.data});
         end
      end
   end

   task automatic post_cpu(input logic we, input logic [10:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_rd);
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      exp_cpu   = exp_rd;
   endtask

   task automatic slot(input logic [2:0] ph, input logic fe);
      int   c;
      logic grant_cpu;
      @(negedge clk);
      c            = cyc;
      ce_7mp       = 1'b1;
      char_phase   = ph;
      vid_fetch_en = fe;
      grant_cpu    = 1'b0;
      if (ph == 3'd7 && fe) begin
         ram_q.push_back('{we: 1'b0, addr: vid_addr, wdata: 8'h00, cyc: c + 1});
         resp_q.push_back('{is_vid: 1'b1, data: exp_vid, cyc: c + 3});
         if (cpu_req) begin
            if (exp_wait16 != 16'hFFFF) exp_wait16++;
            if (exp_wait2 != 2'd3) exp_wait2++;
         end
      end else if (cpu_req) begin
         ram_q.push_back('{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, cyc: c + 1});
         if (!abort_next)
            resp_q.push_back('{is_vid: 1'b0, data: cpu_we ? 8'h00 : exp_cpu, cyc: c + 3});
         grant_cpu = 1'b1;
      end
      @(negedge clk);
      ce_7mp = 1'b0;
      if (grant_cpu) cpu_req = 1'b0;
      if (abort_next) begin
         reset_n = 1'b0;
         @(negedge clk);
         reset_n    = 1'b1;
         abort_next = 1'b0;
         exp_wait16 = '0;
         exp_wait2  = '0;
      end
      repeat (SLOT_LEN - 2) @(negedge clk);
      check("cpu_wait_cnt", {16'd0, cpu_wait_cnt}, {16'd0, exp_wait16});
      check("sat cpu_wait_cnt", {30'd0, s_wait_cnt}, {30'd0, exp_wait2});
   endtask

   task automatic reset_check(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check({tag, " vid_data"},  {24'd0, vid_data}, 32'd0);
      check({tag, " vid_valid"}, {31'd0, vid_valid}, 32'd0);
      check({tag, " cpu_rdata"}, {24'd0, cpu_rdata}, 32'd0);
      check({tag, " cpu_ack"},   {31'd0, cpu_ack}, 32'd0);
      check({tag, " ram_en"},    {31'd0, ram_en}, 32'd0);
      check({tag, " ram_we"},    {31'd0, ram_we}, 32'd0);
      check({tag, " ram_addr"},  {21'd0, ram_addr}, 32'd0);
      check({tag, " ram_wdata"}, {24'd0, ram_wdata}, 32'd0);
      check({tag, " wait_cnt"},  {16'd0, cpu_wait_cnt}, 32'd0);
      check({tag, " sat wait"},  {30'd0, s_wait_cnt}, 32'd0);
      reset_n    = 1'b1;
      exp_wait16 = '0;
      exp_wait2  = '0;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      mem[11'h123] = 8'h41;
      reset_n      = 1'b0;
      ce_7mp       = 1'b0;
      char_phase   = 3'd0;
      vid_fetch_en = 1'b0;
      vid_addr     = 11'h123;
      cpu_req      = 1'b0;
      cpu_we       = 1'b0;
      cpu_addr     = '0;
      cpu_wdata    = '0;
      exp_vid      = 8'h41;
      exp_cpu      = 8'h00;
      exp_wait16   = '0;
      exp_wait2    = '0;
      abort_next   = 1'b0;
      repeat (2) @(negedge clk);
      reset_check("reset");

      // Video fetch of cell 0x123 during active raster.
      slot(3'd7, 1'b1);

      // Blanked CPU write then read-back at the top address.
      post_cpu(1'b1, 11'h7FF, 8'hA5, 8'h00);
      slot(3'd3, 1'b0);
      post_cpu(1'b0, 11'h7FF, 8'h00, 8'hA5);
      slot(3'd4, 1'b0);

      // Collision: video first, CPU granted in the following phase-0 slot.
      post_cpu(1'b0, 11'h123, 8'h00, 8'h41);
      slot(3'd7, 1'b1);
      slot(3'd0, 1'b1);

      // Reset with non-zero held outputs.
      reset_check("reset2");

      // Five collisions: narrow counter saturates at 3.
      for (int k = 0; k < 5; k++) begin
         post_cpu(1'b0, 11'h7FF, 8'h00, 8'hA5);
         slot(3'd7, 1'b1);
         slot(3'd0, 1'b1);
      end

      // Reset one clk after a CPU read grant: no ack, then a normal read.
      post_cpu(1'b0, 11'h123, 8'h00, 8'h41);
      abort_next = 1'b1;
      slot(3'd1, 1'b0);
      post_cpu(1'b0, 11'h123, 8'h00, 8'h41);
      slot(3'd2, 1'b0);

      // Request abandoned before any slot: nothing happens.
      post_cpu(1'b1, 11'h010, 8'h5A, 8'h00);
      @(negedge clk);
      cpu_req = 1'b0;
      slot(3'd5, 1'b0);
      post_cpu(1'b0, 11'h010, 8'h00, 8'h00);
      slot(3'd6, 1'b0);

      repeat (10) @(negedge clk);
      check("resp queue drained", resp_q.size(), 32'd0);
      check("ram queue drained", ram_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
